// File: rtl/cv32e40x_obi_responder.sv
// OBI responder: grants address phases, answers in grant order from a local word memory.
// Define OBI_RESP_STALL_EN to add LFSR-driven pseudo-random grant stalls.
`timescale 1ns/1ps
module cv32e40x_obi_responder #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned MEM_WORDS    = 256,
    parameter int unsigned RESP_LATENCY = 1,
    parameter logic [31:0] ERR_BASE     = 32'hFFFF_0000,
    parameter logic [31:0] ERR_MASK     = 32'hFFFF_0000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  memtype_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned LAT_W = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RESP_LATENCY - 1);

    logic [31:0]      mem_q [MEM_WORDS];
    logic [31:0]      fifo_rdata_q [DEPTH];
    logic [31:0]      fifo_rdata_d [DEPTH];
    logic             fifo_err_q [DEPTH];
    logic             fifo_err_d [DEPTH];
    logic [LAT_W-1:0] fifo_cnt_q [DEPTH];
    logic [LAT_W-1:0] fifo_cnt_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             stall_ok;
    logic             push;
    logic             pop;
    logic             err_hit;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      mem_rd_word;
    logic             mem_we;
    logic             unused_cfg;

    assign unused_cfg = ^{memtype_i, LFSR_SEED};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

`ifdef OBI_RESP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_ok = lfsr_q[0];
`else
    assign stall_ok = 1'b1;
`endif

    // Occupancy is the registered count only, so grant never depends on the response path.
    assign gnt_o       = rst_n && req_i && (count_q < CNT_W'(DEPTH)) && stall_ok;
    assign push        = req_i && gnt_o;
    assign err_hit     = (addr_i & ERR_MASK) == (ERR_BASE & ERR_MASK);
    assign mem_idx     = addr_i[2 +: IDX_W];
    assign mem_rd_word = mem_q[mem_idx];
    assign mem_we      = push && we_i && !err_hit;

    assign rvalid_o = (count_q != '0) && (fifo_cnt_q[head_q] == '0);
    assign pop      = rvalid_o;
    assign rdata_o  = rvalid_o ? fifo_rdata_q[head_q] : 32'h0;
    assign err_o    = rvalid_o ? fifo_err_q[head_q] : 1'b0;

    always_comb begin
        fifo_rdata_d = fifo_rdata_q;
        fifo_err_d   = fifo_err_q;
        fifo_cnt_d   = fifo_cnt_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (fifo_cnt_q[i] != '0) begin
                fifo_cnt_d[i] = fifo_cnt_q[i] - LAT_W'(1);
            end
        end

        if (push) begin
            fifo_rdata_d[tail_q] = (we_i || err_hit) ? 32'h0 : mem_rd_word;
            fifo_err_d[tail_q]   = err_hit;
            fifo_cnt_d[tail_q]   = LAT_INIT;
            tail_d               = ptr_inc(tail_q);
        end

        if (pop) begin
            head_d = ptr_inc(head_q);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_rdata_q[i] <= '0;
                fifo_err_q[i]   <= 1'b0;
                fifo_cnt_q[i]   <= '0;
            end
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            fifo_rdata_q <= fifo_rdata_d;
            fifo_err_q   <= fifo_err_d;
            fifo_cnt_q   <= fifo_cnt_d;
        end
    end

    // Writes land at the end of the grant cycle, so a later-granted read sees them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned w = 0; w < MEM_WORDS; w++) begin
                mem_q[w] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we && be_i[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule
